// File: rtl/sha3_pkg.sv
// ----------------------------------------------------------------------------
// sha3_pkg
// Shared Keccak types and helpers used by the SHA-3 absorb and squeeze paths.
//   lane_t        one 64-bit Keccak lane
//   row_t         five lanes of one state row, element [x] is lane (x,y)
//   sq_state_e    squeeze serializer FSM states
//   lane_idx()    flat lane number x+5*y
//   bswap64()     byte reversal of a lane (little-endian lane -> big-endian)
// ----------------------------------------------------------------------------
package sha3_pkg;

   localparam int KECCAK_LANES = 25;

   typedef logic [63:0] lane_t;
   typedef lane_t row_t [5];

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } sq_state_e;

   // Flat lane number of lane (x,y) in the 5x5 state
   function automatic int lane_idx(input int x, input int y);
      return x + 5 * y;
   endfunction

   // Byte 0 of the lane lands in bits 63:56
   function automatic lane_t bswap64(input lane_t v);
      lane_t r;
      r = 64'h0;
      for (int b = 0; b < 8; b++) begin
         r[8*(7-b) +: 8] = v[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/sha3_squeeze_serializer.sv
// ----------------------------------------------------------------------------
// sha3_squeeze_serializer
// Captures a full Keccak state from the round pipeline when good pulses and
// emits the first DIGEST_LANES lanes, one lane per transfer, on a valid/ready
// stream. The round pipeline cannot stall, so a state offered while the
// serializer is busy is dropped and flagged on overrun.
//
// Parameters
//   DIGEST_LANES   lanes emitted per state, 1..25
// Ports
//   clk            clock
//   rst            synchronous active-high reset
//   isa..ise       state rows y=0..4, is<row>[x] = lane (x,y)
//   good           one-cycle strobe, rows valid this cycle
//   state_ready    a state offered this cycle will be captured
//   dout           current lane
//   dout_valid     dout holds a lane
//   dout_ready     downstream accepts dout
//   dout_last      dout is lane DIGEST_LANES-1
//   overrun        one-cycle pulse, a state was dropped the previous cycle
// Configuration
//   SHA3_SQUEEZE_BYTESWAP_EN  when defined, dout is the byte-reversed lane
//                             (big-endian digest stream); handshakes unchanged
// ----------------------------------------------------------------------------
module sha3_squeeze_serializer
   import sha3_pkg::*;
#(
   parameter int DIGEST_LANES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  row_t        isa,
   input  row_t        isb,
   input  row_t        isc,
   input  row_t        isd,
   input  row_t        ise,
   input  logic        good,
   output logic        state_ready,
   output logic [63:0] dout,
   output logic        dout_valid,
   input  logic        dout_ready,
   output logic        dout_last,
   output logic        overrun
);

   localparam int IDX_W = $clog2(DIGEST_LANES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGEST_LANES - 1);

   if (DIGEST_LANES < 1 || DIGEST_LANES > KECCAK_LANES) begin : g_bad_lanes
      $error("sha3_squeeze_serializer: DIGEST_LANES must be within 1..25");
   end

   sq_state_e        r_state;
   sq_state_e        w_state_nxt;
   logic [IDX_W-1:0] r_idx;
   lane_t            r_buf [DIGEST_LANES];
   logic             r_overrun;

   lane_t            w_lanes [KECCAK_LANES];
   lane_t            w_lane_sel;
   logic             w_emit;
   logic             w_transfer;
   logic             w_last;
   logic             w_state_ready;
   logic             w_capture;

   // Flatten the five input rows into lane order x+5*y
   always_comb begin
      for (int i = 0; i < KECCAK_LANES; i++) begin
         w_lanes[i] = 64'h0;
      end
      for (int x = 0; x < 5; x++) begin
         w_lanes[lane_idx(x, 0)] = isa[x];
         w_lanes[lane_idx(x, 1)] = isb[x];
         w_lanes[lane_idx(x, 2)] = isc[x];
         w_lanes[lane_idx(x, 3)] = isd[x];
         w_lanes[lane_idx(x, 4)] = ise[x];
      end
   end

   // Handshake decode; state_ready sees dout_ready directly so a final
   // transfer can hand off to the next state with no bubble
   always_comb begin
      w_emit        = (r_state == ST_EMIT);
      w_transfer    = w_emit & dout_ready;
      w_last        = w_emit & (r_idx == LAST_IDX);
      w_state_ready = ~w_emit | (w_transfer & w_last);
      w_capture     = good & w_state_ready;
   end

   // FSM next-state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (good) w_state_nxt = ST_EMIT;
            else      w_state_nxt = ST_IDLE;
         end
         ST_EMIT: begin
            if (w_transfer & w_last) w_state_nxt = w_capture ? ST_EMIT : ST_IDLE;
            else                     w_state_nxt = ST_EMIT;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Lane buffer, lane index and overrun flag
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DIGEST_LANES; i++) begin
            r_buf[i] <= 64'h0;
         end
         r_idx     <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= good & ~w_state_ready;
         if (w_capture) begin
            for (int i = 0; i < DIGEST_LANES; i++) begin
               r_buf[i] <= w_lanes[i];
            end
            r_idx <= '0;
         end else if (w_transfer) begin
            if (w_last) r_idx <= '0;
            else        r_idx <= r_idx + IDX_W'(1);
         end else begin
            r_idx <= r_idx;
         end
      end
   end

   // Output lane select; the buffer only changes on capture, so dout holds
   // steady through any stall
   always_comb begin
      w_lane_sel = r_buf[r_idx];
   end

`ifdef SHA3_SQUEEZE_BYTESWAP_EN
   assign dout = bswap64(w_lane_sel);
`else
   assign dout = w_lane_sel;
`endif

   assign dout_valid  = w_emit;
   assign dout_last   = w_last;
   assign state_ready = w_state_ready;
   assign overrun     = r_overrun;

endmodule
